keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans the 4x4 Pmod keypad on JA directly. It drives the column lines, samples the row lines, debounces, and emits one single-cycle press event per physical key press with the decoded hex code. It sits between the JA pins and the game logic controller, replacing the free-running decoder. The decoder holds the last code and cannot signal a release or a repeated press of the same key; this block can. It runs on the divided clock `dclk` and its outputs feed the game logic controller's key input directly.

## Interface
Parameters:
- `SETTLE_CYCLES`, 1000: dwell per column in clock cycles; legal range ≥ 4.
- `DEBOUNCE_SCANS`, 4: consecutive identical full sweeps required to accept a press or a release; legal range ≥ 1.

Ports:
- `clk`  in  1  scan clock (`dclk` at top level).
- `reset`  in  1  asynchronous, active-high reset.
- `row`  in  4  keypad rows, active-low, asynchronous to `clk` (JA[7:4]).
- `col`  out  4  keypad column drive, active-low, exactly one bit low at any time (JA[3:0]).
- `key_code`  out  4  hex code of the last accepted key; holds until the next accepted press.
- `key_strobe`  out  1  single-cycle pulse when a press is accepted.
- `key_held`  out  1  high from acceptance of a press until its release is accepted.

## Operation
- `row` passes through a 2-flop synchronizer before any use.
- Column scan: col0 to col3 in order, then wraps. Drive pattern per column: 1110, 1101, 1011, 0111. Each column is driven for `SETTLE_CYCLES` cycles. The synchronized `row` is sampled on the last cycle of the dwell.
- Key map (row r0..r3 top to bottom, col c0..c3 left to right):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Sweep candidate: the first low row found, by lowest column first, then lowest row. If no row is low in any column, the candidate is "none". With several keys down, this priority picks the winner.
- Debounce FSM, evaluated once per completed sweep:
  - IDLE: if the candidate k equals the previous sweep's candidate, increment the count; otherwise set count = 1. "none" resets count to 0. When count reaches `DEBOUNCE_SCANS` with k ≠ none: `key_code`←k, pulse `key_strobe`, set `key_held`=1, go to PRESSED, clear count.
  - PRESSED: a sweep whose candidate is not the latched key increments the release count; a sweep matching the latched key clears it. At `DEBOUNCE_SCANS`: set `key_held`=0, go to IDLE.
- No auto-repeat. A held key produces exactly one strobe. Pressing a different key while in PRESSED produces no strobe until the release is accepted and the new key then debounces.
- Counter widths: `$clog2(SETTLE_CYCLES)` for the dwell counter and `$clog2(DEBOUNCE_SCANS+1)` for the debounce counters. Both saturate or clear as described and never wrap silently.

## Timing
- Reset values: `col`=1110, `key_code`=0, `key_strobe`=0, `key_held`=0, FSM=IDLE, all counters 0, synchronizer flops 1 (released).
- A sweep lasts 4×`SETTLE_CYCLES` cycles.
- The sweep result is evaluated in the cycle after the col3 sample. `key_strobe` and `key_held` update in that same cycle, registered, and `key_strobe` is high for exactly 1 cycle.
- Worst-case press latency, from a stable key-down to the strobe: (`DEBOUNCE_SCANS`+1) sweeps + 2 cycles.
- Release latency: up to (`DEBOUNCE_SCANS`+1) sweeps.
- A reset asserted mid-scan or mid-press immediately forces all reset values. After reset deasserts, a key still held is treated as a new press and re-debounced.

## Structure
- The shared package `nim_pkg` holds:
  - the 16-entry key-map constant (row, col → code);
  - `NUM_ROWS`/`NUM_COLS`=4;
  - the FSM state enum (IDLE, PRESSED).
- One sub-module: `sync_2ff`, a 4-bit two-flop synchronizer for `row` with asynchronous reset to 1.
- The top level instantiates `keypad_scanner` on `dclk`. `key_strobe` and `key_code` go to the game logic controller.

## Test plan
All scenarios use `SETTLE_CYCLES`=8 and `DEBOUNCE_SCANS`=3, giving a 32-cycle sweep.
- Reset, no keys: `col` sequence is 1110→1101→1011→0111→1110 every 8 cycles, and all outputs stay 0 over 10 sweeps.
- Hold r1c2 ('6') for 10 sweeps: exactly one `key_strobe`, with `key_code`=6, `key_held`=1, strobe within 4 sweeps + 2 cycles of key-down.
- Bounce r0c3 ('A') on and off on alternate sweeps for 8 sweeps: no strobe, `key_held` stays 0.
- Press '6', release, then press '6' again, each held 6 sweeps: two strobes, `key_held` falls 3 to 4 sweeps after each release.
- Hold r0c0 ('1') and r3c3 ('D') together: one strobe with `key_code`=1.
- Assert `reset` for 3 cycles while '9' (r2c2) is held in PRESSED: outputs go to 0 and `col`=1110 immediately. After reset releases with the key still down, one new strobe arrives with `key_code`=9.

Source files
------------

// File: rtl/nim_pkg.sv
// nim_pkg: shared keypad constants, key map and debounce state type
package nim_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    // Nibble {row,col} holds the hex legend of that key.
    // Rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D
    localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

    typedef enum logic {IDLE, PRESSED} state_t;

    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        return KEY_MAP[{r, c, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer, flops reset to 1 so idle active-low lines read released
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scan, debounce and single-pulse press events
module keypad_scanner
    import nim_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic [3:0]          key_code,
    output logic                key_strobe,
    output logic                key_held
);

    localparam int DW = $clog2(SETTLE_CYCLES);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    logic [3:0]    row_s;
    logic [DW-1:0] dwell;
    logic [1:0]    col_idx;
    logic          acc_valid;
    logic [3:0]    acc_code;
    logic          sw_done;
    logic          sw_valid;
    logic [3:0]    sw_code;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] rel;
    logic          prev_valid;
    logic [3:0]    prev_code;

    logic          sample;
    logic          hit;
    logic [1:0]    hit_row;
    logic [3:0]    hit_code;
    logic          cur_valid;
    logic [3:0]    cur_code;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] rel_nxt;

    sync_2ff #(.W(NUM_ROWS)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row),
        .q     (row_s)
    );

    assign col = ~(4'b0001 << col_idx);

    // Per-column hit and the running sweep candidate (earlier column wins, then lower row)
    always_comb begin
        sample    = dwell == DW'(SETTLE_CYCLES - 1);
        hit       = row_s != 4'hF;
        hit_row   = !row_s[0] ? 2'd0 : !row_s[1] ? 2'd1 : !row_s[2] ? 2'd2 : 2'd3;
        hit_code  = key_lookup(hit_row, col_idx);
        cur_valid = (col_idx == 2'd0) ? hit : (acc_valid | hit);
        cur_code  = (col_idx != 2'd0 && acc_valid) ? acc_code : hit_code;
        cnt_nxt   = !sw_valid ? '0 : (prev_valid && sw_code == prev_code) ? cnt + 1'b1 : CW'(1);
        rel_nxt   = (sw_valid && sw_code == key_code) ? '0 : rel + 1'b1;
    end

    // Column dwell timer, row sampling and end-of-sweep capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell     <= '0;
            col_idx   <= '0;
            acc_valid <= 1'b0;
            acc_code  <= '0;
            sw_done   <= 1'b0;
            sw_valid  <= 1'b0;
            sw_code   <= '0;
        end else begin
            sw_done <= sample && col_idx == 2'd3;
            dwell   <= sample ? '0 : dwell + 1'b1;
            if (sample) begin
                col_idx   <= col_idx + 2'd1;
                acc_valid <= cur_valid;
                acc_code  <= cur_code;
                if (col_idx == 2'd3) begin
                    sw_valid <= cur_valid;
                    sw_code  <= cur_code;
                end
            end
        end
    end

    // Debounce FSM: accept a press after stable sweeps, then wait for a stable release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            rel        <= '0;
            prev_valid <= 1'b0;
            prev_code  <= '0;
            key_code   <= '0;
            key_strobe <= 1'b0;
            key_held   <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (sw_done) begin
                prev_valid <= sw_valid;
                prev_code  <= sw_code;
                if (state == IDLE) begin
                    if (cnt_nxt == CW'(DEBOUNCE_SCANS)) begin
                        key_code   <= sw_code;
                        key_strobe <= 1'b1;
                        key_held   <= 1'b1;
                        state      <= PRESSED;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end else if (rel_nxt == CW'(DEBOUNCE_SCANS)) begin
                    key_held <= 1'b0;
                    state    <= IDLE;
                    rel      <= '0;
                end else begin
                    rel <= rel_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed test of scanning, debounce, multi-key priority and reset
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_strobe;
    logic        key_held;
    logic [15:0] keys = '0;

    int tests = 0;
    int fails = 0;

    int          cyc = 0;
    int          wraps = 0;
    int          strobes = 0;
    int          strobe_cyc = 0;
    int          fall_wraps = 0;
    int          held_rises = 0;
    logic [3:0]  last_code = '0;
    logic [3:0]  prev_col = 4'b1110;
    logic        prev_held = 1'b0;

    int press_cyc, r0, r1, d1, d2;

    keypad_scanner #(.SETTLE_CYCLES(8), .DEBOUNCE_SCANS(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .row        (row),
        .col        (col),
        .key_code   (key_code),
        .key_strobe (key_strobe),
        .key_held   (key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven low
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    // Event monitor sampled on the falling edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (col == 4'b1110 && prev_col == 4'b0111) wraps = wraps + 1;
        if (key_strobe) begin
            strobes = strobes + 1;
            last_code = key_code;
            strobe_cyc = cyc;
        end
        if (prev_held && !key_held) fall_wraps = wraps;
        if (!prev_held && key_held) held_rises = held_rises + 1;
        prev_col = col;
        prev_held = key_held;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tick(3);
        check("rst_col", 32'(col), 32'h0E);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_strobe", 32'(key_strobe), 32'h0);
        check("rst_held", 32'(key_held), 32'h0);
        reset = 1'b0;
        tick(4);
        check("col0", 32'(col), 32'h0E);
        tick(8);
        check("col1", 32'(col), 32'h0D);
        tick(8);
        check("col2", 32'(col), 32'h0B);
        tick(8);
        check("col3", 32'(col), 32'h07);
        tick(8);
        check("col_wrap", 32'(col), 32'h0E);
        tick(320);
        check("idle_strobes", 32'(strobes), 32'd0);
        check("idle_held_rises", 32'(held_rises), 32'd0);

        keys = 16'h0040;
        press_cyc = cyc;
        tick(320);
        check("hold6_strobes", 32'(strobes), 32'd1);
        check("hold6_code", 32'(last_code), 32'h6);
        check("hold6_held", 32'(key_held), 32'h1);
        check("hold6_latency_ok", 32'((strobe_cyc - press_cyc) <= 130), 32'h1);
        keys = '0;
        r0 = wraps;
        tick(192);
        check("rel6_held", 32'(key_held), 32'h0);
        check("rel6_sweeps_ok", 32'((fall_wraps - r0) >= 3 && (fall_wraps - r0) <= 4), 32'h1);

        for (int i = 0; i < 4; i++) begin
            keys = 16'h0008;
            tick(32);
            keys = '0;
            tick(32);
        end
        tick(96);
        check("bounce_strobes", 32'(strobes), 32'd1);
        check("bounce_held_rises", 32'(held_rises), 32'd1);
        check("bounce_held", 32'(key_held), 32'h0);

        keys = 16'h0040;
        tick(192);
        keys = '0;
        r0 = wraps;
        tick(192);
        d1 = fall_wraps - r0;
        keys = 16'h0040;
        tick(192);
        keys = '0;
        r1 = wraps;
        tick(192);
        d2 = fall_wraps - r1;
        check("repress_strobes", 32'(strobes), 32'd3);
        check("repress_code", 32'(last_code), 32'h6);
        check("repress_rel1_ok", 32'(d1 >= 3 && d1 <= 4), 32'h1);
        check("repress_rel2_ok", 32'(d2 >= 3 && d2 <= 4), 32'h1);
        check("repress_held", 32'(key_held), 32'h0);

        keys = 16'h8001;
        tick(192);
        check("multi_strobes", 32'(strobes), 32'd4);
        check("multi_code", 32'(last_code), 32'h1);
        check("multi_held", 32'(key_held), 32'h1);
        keys = '0;
        tick(192);
        check("multi_rel_held", 32'(key_held), 32'h0);

        keys = 16'h0400;
        tick(192);
        check("nine_strobes", 32'(strobes), 32'd5);
        check("nine_code", 32'(key_code), 32'h9);
        check("nine_held", 32'(key_held), 32'h1);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_col", 32'(col), 32'h0E);
        check("mid_rst_code", 32'(key_code), 32'h0);
        check("mid_rst_held", 32'(key_held), 32'h0);
        check("mid_rst_strobe", 32'(key_strobe), 32'h0);
        tick(3);
        reset = 1'b0;
        tick(192);
        check("post_rst_strobes", 32'(strobes), 32'd6);
        check("post_rst_code", 32'(key_code), 32'h9);
        check("post_rst_held", 32'(key_held), 32'h1);
        keys = '0;
        tick(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
